// File: rtl/slug_sequencer.sv
// slug_sequencer: phase sequencer for the slug 4-bit core.
// Turns the raw 24-bit microcode word {control2,control1,control0} into
// phase-timed strobes: FETCH -> SETUP -> [MEM x RAM_WAIT] -> COMMIT, with
// halt / single-step and a sticky error for bus-contention words.
//
// Microcode bit map (raw ROM polarity, _n = active-low):
//   control2 [7] ldalu_n [6] oealu_n [5] ldfl_n [4] lda_n [3] oeop_n [2:0] sel
//   control1 [7] unused  [6] oec_n   [5] oeb_n  [4] ldbc_n [3] oein_n
//            [2] ldout_n [1] reram_n [0] weram_n
//   control0 [7:4] alus  [3] alum    [2] crin_n [1] ldpc_n [0] incpc
module slug_sequencer #(
  parameter int FETCH_WAIT = 1,
  parameter int RAM_WAIT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] ucode,
  input  logic        halt_req,
  input  logic        step,
  output logic        oec,
  output logic        oeb,
  output logic        oein,
  output logic        oeop,
  output logic        oealu,
  output logic        reram,
  output logic        ldbc,
  output logic        ldout,
  output logic        ldalu,
  output logic        ldfl,
  output logic        lda,
  output logic        weram,
  output logic        ldpc,
  output logic        incpc,
  output logic [2:0]  sel,
  output logic [3:0]  alus,
  output logic        alum,
  output logic        crin,
  output logic        instr_done,
  output logic        halted,
  output logic        err
);

  localparam int MAXW = (FETCH_WAIT > RAM_WAIT) ? FETCH_WAIT : RAM_WAIT;
  localparam int CW   = (MAXW < 2) ? 1 : $clog2(MAXW);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    SETUP  = 3'd1,
    MEM    = 3'd2,
    COMMIT = 3'd3,
    HALT   = 3'd4
  } state_t;

  // Decoded word in core polarity (everything active-high).
  typedef struct packed {
    logic       oec, oeb, oein, oeop, oealu, reram;
    logic       ldbc, ldout, ldalu, ldfl, lda, weram, ldpc, incpc;
    logic [2:0] sel;
    logic [3:0] alus;
    logic       alum, crin;
  } dec_t;

  // w = {control2, control1[6:0], control0}; control1[7] carries nothing.
  function automatic dec_t decode(input logic [22:0] w);
    dec_t       d;
    logic [7:0] c2;
    logic [6:0] c1;
    logic [7:0] c0;
    c2      = w[22:15];
    c1      = w[14:8];
    c0      = w[7:0];
    d.oec   = ~c1[6];
    d.oeb   = ~c1[5];
    d.ldbc  = ~c1[4];
    d.oein  = ~c1[3];
    d.ldout = ~c1[2];
    d.reram = ~c1[1];
    d.weram = ~c1[0];
    d.ldalu = ~c2[7];
    d.oealu = ~c2[6];
    d.ldfl  = ~c2[5];
    d.lda   = ~c2[4];
    d.oeop  = ~c2[3];
    d.sel   = c2[2:0];
    d.alus  = c0[7:4];
    d.alum  = c0[3];
    d.crin  = ~c0[2];
    d.ldpc  = ~c0[1];
    d.incpc = c0[0];
    return d;
  endfunction

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [23:0]    ir_q, ir_d;
  logic           step_run_q, step_run_d;
  logic           err_q, err_d;

  dec_t           dec_ir;
  logic           ir_ill;
  logic           ill_in;
  logic           need_mem;
  logic           unused_rsvd;

  assign dec_ir      = decode({ir_q[23:16], ir_q[14:0]});
  assign ir_ill      = (dec_ir.oeb & dec_ir.oec) | (dec_ir.oeop & dec_ir.oein);
  // Same contention test on the incoming raw word: oec_n/oeb_n/oein_n/oeop_n low.
  assign ill_in      = (~ucode[14] & ~ucode[13]) | (~ucode[19] & ~ucode[11]);
  assign need_mem    = (RAM_WAIT > 0) && (dec_ir.reram | dec_ir.weram);
  assign unused_rsvd = ir_q[15];
  assign err         = err_q;

  // State, counter, instruction register and flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      cnt_q      <= '0;
      ir_q       <= '0;
      step_run_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ir_q       <= ir_d;
      step_run_q <= step_run_d;
      err_q      <= err_d;
    end
  end

  // Next-state: phase walk, wait counting, halt/step handling.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ir_d       = ir_q;
    step_run_d = step_run_q;
    err_d      = err_q;
    case (state_q)
      FETCH: begin
        if (cnt_q == CW'(FETCH_WAIT - 1)) begin
          cnt_d   = '0;
          ir_d    = ucode;
          state_d = SETUP;
          if (ill_in) err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = need_mem ? MEM : COMMIT;
      end
      MEM: begin
        if (cnt_q == CW'(RAM_WAIT - 1)) begin
          cnt_d   = '0;
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      COMMIT: begin
        // halt_req is only looked at here so an instruction is never cut short.
        cnt_d      = '0;
        step_run_d = 1'b0;
        state_d    = (halt_req || step_run_q) ? HALT : FETCH;
      end
      HALT: begin
        cnt_d = '0;
        if (step) begin
          step_run_d = 1'b1;
          state_d    = FETCH;
        end else if (!halt_req) begin
          state_d = FETCH;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = FETCH;
      end
    endcase
  end

  // Outputs: enables span SETUP..COMMIT, loads fire only in COMMIT,
  // and an illegal word suppresses every enable and load.
  always_comb begin
    logic act, en_ok, ld_ok;
    act   = (state_q == SETUP) || (state_q == MEM) || (state_q == COMMIT);
    en_ok = act && !ir_ill;
    ld_ok = (state_q == COMMIT) && !ir_ill;

    oec        = en_ok & dec_ir.oec;
    oeb        = en_ok & dec_ir.oeb;
    oein       = en_ok & dec_ir.oein;
    oeop       = en_ok & dec_ir.oeop;
    oealu      = en_ok & dec_ir.oealu;
    reram      = en_ok & dec_ir.reram;

    ldbc       = ld_ok & dec_ir.ldbc;
    ldout      = ld_ok & dec_ir.ldout;
    ldalu      = ld_ok & dec_ir.ldalu;
    ldfl       = ld_ok & dec_ir.ldfl;
    lda        = ld_ok & dec_ir.lda;
    weram      = ld_ok & dec_ir.weram;
    ldpc       = ld_ok & dec_ir.ldpc;
    incpc      = ld_ok & dec_ir.incpc & ~dec_ir.ldpc;   // jump beats increment

    sel        = act ? dec_ir.sel  : 3'd0;
    alus       = act ? dec_ir.alus : 4'd0;
    alum       = act & dec_ir.alum;
    crin       = act & dec_ir.crin;

    instr_done = (state_q == COMMIT);
    halted     = (state_q == HALT);
  end

endmodule

// File: tb/tb_slug_sequencer.sv
// tb_slug_sequencer: directed vector table plus hand sequences for reset corners.
module tb_slug_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] ucode;
  logic        halt_req, step;
  logic oec, oeb, oein, oeop, oealu, reram;
  logic ldbc, ldout, ldalu, ldfl, lda, weram, ldpc, incpc;
  logic [2:0] sel;
  logic [3:0] alus;
  logic alum, crin, instr_done, halted, err;

  slug_sequencer #(.FETCH_WAIT(1), .RAM_WAIT(2)) dut (
    .clk(clk), .rst(rst), .ucode(ucode), .halt_req(halt_req), .step(step),
    .oec(oec), .oeb(oeb), .oein(oein), .oeop(oeop), .oealu(oealu), .reram(reram),
    .ldbc(ldbc), .ldout(ldout), .ldalu(ldalu), .ldfl(ldfl), .lda(lda),
    .weram(weram), .ldpc(ldpc), .incpc(incpc), .sel(sel), .alus(alus),
    .alum(alum), .crin(crin), .instr_done(instr_done), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  // Observed groups: en {oec,oeb,oein,oeop,oealu,reram}
  //                  ld {ldbc,ldout,ldalu,ldfl,lda,weram,ldpc,incpc}
  //                  ax {sel,alus,alum,crin}   fl {instr_done,halted,err}
  logic [5:0]  en;
  logic [7:0]  ld;
  logic [8:0]  ax;
  logic [2:0]  fl;
  logic [25:0] all_o;
  assign en    = {oec, oeb, oein, oeop, oealu, reram};
  assign ld    = {ldbc, ldout, ldalu, ldfl, lda, weram, ldpc, incpc};
  assign ax    = {sel, alus, alum, crin};
  assign fl    = {instr_done, halted, err};
  assign all_o = {en, ld, ax, fl};

  // Raw microcode words (active-low fields idle high).
  localparam logic [23:0] ALU = 24'h3D_7F_AE; // ldalu,oealu; sel=5 alus=A alum=1
  localparam logic [23:0] RD  = 24'hE8_7D_06; // reram,lda
  localparam logic [23:0] JMP = 24'hF8_7F_01; // ldpc,incpc,crin
  localparam logic [23:0] ILL = 24'hF8_1F_04; // oec+oeb contention, ldpc
  localparam logic [23:0] WR  = 24'hF8_5E_06; // oeb,weram

  localparam logic [5:0] EN_ALU = 6'b000010;
  localparam logic [5:0] EN_RD  = 6'b000001;
  localparam logic [5:0] EN_WR  = 6'b010000;
  localparam logic [7:0] LD_ALU = 8'b0010_0000;
  localparam logic [7:0] LD_RD  = 8'b0000_1000;
  localparam logic [7:0] LD_JMP = 8'b0000_0010;
  localparam logic [7:0] LD_WR  = 8'b0000_0100;
  localparam logic [8:0] AX_ALU = 9'b101_1010_10;
  localparam logic [8:0] AX_JMP = 9'b000_0000_01;

  typedef struct {
    logic [23:0] u;
    logic        h, s;
    logic [5:0]  en;
    logic [7:0]  ld;
    logic [8:0]  ax;
    logic [2:0]  fl;
  } vec_t;

  vec_t tv[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic [23:0] u, input logic h, input logic s,
                     input logic [5:0] e, input logic [7:0] l,
                     input logic [8:0] a, input logic [2:0] f);
    vec_t v;
    v.u = u; v.h = h; v.s = s; v.en = e; v.ld = l; v.ax = a; v.fl = f;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Columns: ucode, halt_req, step | expected en, ld, ax, fl after the edge.
    add(ALU,0,0, EN_ALU,0,     AX_ALU,3'b000); // 0 SETUP
    add(ALU,0,0, EN_ALU,LD_ALU,AX_ALU,3'b100); // 1 COMMIT
    add(ALU,0,0, 0,     0,     0,     3'b000); // 2 FETCH
    add(ALU,0,0, EN_ALU,0,     AX_ALU,3'b000); // 3 SETUP
    add(RD ,0,0, EN_ALU,LD_ALU,AX_ALU,3'b100); // 4 COMMIT, ucode change ignored
    add(RD ,0,0, 0,     0,     0,     3'b000); // 5 FETCH
    add(RD ,0,0, EN_RD, 0,     0,     3'b000); // 6 SETUP
    add(RD ,0,0, EN_RD, 0,     0,     3'b000); // 7 MEM
    add(RD ,0,0, EN_RD, 0,     0,     3'b000); // 8 MEM
    add(RD ,0,0, EN_RD, LD_RD, 0,     3'b100); // 9 COMMIT
    add(JMP,0,0, 0,     0,     0,     3'b000); // 10 FETCH
    add(JMP,0,0, 0,     0,     AX_JMP,3'b000); // 11 SETUP
    add(JMP,0,0, 0,     LD_JMP,AX_JMP,3'b100); // 12 COMMIT: ldpc=1 incpc=0
    add(RD ,0,0, 0,     0,     0,     3'b000); // 13 FETCH
    add(RD ,0,0, EN_RD, 0,     0,     3'b000); // 14 SETUP
    add(RD ,1,0, EN_RD, 0,     0,     3'b000); // 15 MEM, halt_req rises
    add(RD ,1,0, EN_RD, 0,     0,     3'b000); // 16 MEM
    add(RD ,1,0, EN_RD, LD_RD, 0,     3'b100); // 17 COMMIT completes
    add(RD ,1,0, 0,     0,     0,     3'b010); // 18 HALT
    add(ALU,1,0, 0,     0,     0,     3'b010); // 19 HALT holds
    add(ALU,1,1, 0,     0,     0,     3'b000); // 20 step -> FETCH
    add(ALU,1,0, EN_ALU,0,     AX_ALU,3'b000); // 21 SETUP
    add(ALU,1,0, EN_ALU,LD_ALU,AX_ALU,3'b100); // 22 COMMIT
    add(ALU,1,0, 0,     0,     0,     3'b010); // 23 back to HALT
    add(ALU,1,0, 0,     0,     0,     3'b010); // 24 HALT
    add(ILL,0,0, 0,     0,     0,     3'b000); // 25 release -> FETCH
    add(ILL,0,0, 0,     0,     0,     3'b001); // 26 SETUP, err set
    add(ILL,0,0, 0,     0,     0,     3'b101); // 27 COMMIT, no ldpc
    add(ALU,0,0, 0,     0,     0,     3'b001); // 28 FETCH
    add(ALU,0,0, EN_ALU,0,     AX_ALU,3'b001); // 29 SETUP, err sticky
    add(ALU,0,0, EN_ALU,LD_ALU,AX_ALU,3'b101); // 30 COMMIT
    add(ALU,1,0, 0,     0,     0,     3'b011); // 31 HALT
    add(ALU,0,1, 0,     0,     0,     3'b001); // 32 step + release together
    add(ALU,0,0, EN_ALU,0,     AX_ALU,3'b001); // 33 SETUP
    add(ALU,0,0, EN_ALU,LD_ALU,AX_ALU,3'b101); // 34 COMMIT
    add(ALU,0,0, 0,     0,     0,     3'b011); // 35 step-run returns to HALT
    add(ALU,0,0, 0,     0,     0,     3'b001); // 36 FETCH
    add(ALU,0,1, EN_ALU,0,     AX_ALU,3'b001); // 37 step outside HALT ignored
    add(ALU,0,0, EN_ALU,LD_ALU,AX_ALU,3'b101); // 38 COMMIT
    add(ALU,0,0, 0,     0,     0,     3'b001); // 39 FETCH (no step-run)

    rst = 1'b0; ucode = ALU; halt_req = 1'b0; step = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 0, 32'(all_o), 32'd0);
    @(negedge clk);
    chk("reset_outputs", 1, 32'(all_o), 32'd0);
    rst = 1'b1;

    foreach (tv[i]) begin
      ucode = tv[i].u; halt_req = tv[i].h; step = tv[i].s;
      tick();
      chk("vec_en", i, 32'(en), 32'(tv[i].en));
      chk("vec_ld", i, 32'(ld), 32'(tv[i].ld));
      chk("vec_ax", i, 32'(ax), 32'(tv[i].ax));
      chk("vec_fl", i, 32'(fl), 32'(tv[i].fl));
    end
    step = 1'b0; halt_req = 1'b0;

    // Reset while a RAM write sits in MEM.
    ucode = WR;
    tick();
    chk("wr_setup_en", 0, 32'(en), 32'(EN_WR));
    tick();
    chk("wr_mem_en", 0, 32'(en), 32'(EN_WR));
    chk("wr_mem_ld", 0, 32'(ld), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_mid_mem_async", 0, 32'(all_o), 32'd0);
    tick();
    chk("rst_held", 0, 32'(all_o), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_fetch_len", 0, 32'(en), 32'(EN_WR));
    chk("post_rst_err_clear", 0, 32'(fl), 32'd0);
    tick();
    tick();
    tick();
    chk("wr_commit_ld", 0, 32'(ld), 32'(LD_WR));
    chk("wr_commit_fl", 0, 32'(fl), 32'b100);

    // Reset mid-COMMIT drops weram without waiting for a clock.
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_commit_async", 0, 32'(all_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
